// File: rtl/grf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package grf_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_ZERO   = 0;

   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending bits, read-port busy masks and pending count.
module grf_scoreboard
   import grf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NREAD  = 2
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   input  logic                    we0,
   input  logic [ADDR_W-1:0]       wa0,
   input  logic                    we1,
   input  logic [ADDR_W-1:0]       wa1,
   input  logic                    rsv_en,
   input  logic [ADDR_W-1:0]       rsv_addr,
   output logic [NREAD-1:0]        rbusy,
   output logic [ADDR_W:0]         pend_cnt
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(REG_ZERO);

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic             v0, v1, vr;
   logic             inc, dec0, dec1;

   assign v0 = we0 && (wa0 != ZA);
   assign v1 = we1 && (wa1 != ZA);
   assign vr = rsv_en && (rsv_addr != ZA);

   always_comb begin
      pend_d = pend_q;
      for (int r = 1; r < DEPTH; r++) begin
         if (vr && rsv_addr == ADDR_W'(r)) begin
            pend_d[r] = 1'b1;
         end else if ((v0 && wa0 == ADDR_W'(r)) ||
                      (v1 && wa1 == ADDR_W'(r))) begin
            pend_d[r] = 1'b0;
         end
      end
      pend_d[0] = 1'b0;
   end

   // Same address on both write ports clears only one pending bit.
   always_comb begin
      inc   = vr && !pend_q[rsv_addr];
      dec0  = v0 && pend_q[wa0] && !(vr && rsv_addr == wa0);
      dec1  = v1 && pend_q[wa1] && !(vr && rsv_addr == wa1)
              && !(v0 && wa0 == wa1);
      cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc}
                    - {{ADDR_W{1'b0}}, dec0}
                    - {{ADDR_W{1'b0}}, dec1};
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_busy
      logic [ADDR_W-1:0] a;
      assign a = raddr[slice_lo(k, ADDR_W) +: ADDR_W];
      assign rbusy[k] = pend_q[a] && (a != ZA)
                        && !(we0 && wa0 == a)
                        && !(we1 && wa1 == a);
   end

   assign pend_cnt = cnt_q;
endmodule

// File: rtl/grf_mp.sv
// Multi-port register file: storage, write-through bypass, scoreboard.
module grf_mp
   import grf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NREAD  = 2
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   output logic [NREAD*DATA_W-1:0] rdata,
   output logic [NREAD-1:0]        rbusy,
   input  logic                    we0,
   input  logic [ADDR_W-1:0]       wa0,
   input  logic [DATA_W-1:0]       wd0,
   input  logic                    we1,
   input  logic [ADDR_W-1:0]       wa1,
   input  logic [DATA_W-1:0]       wd1,
   input  logic                    rsv_en,
   input  logic [ADDR_W-1:0]       rsv_addr,
   output logic [ADDR_W:0]         pend_cnt
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic              v0, v1;

   assign v0 = we0 && (wa0 != ZA);
   assign v1 = we1 && (wa1 != ZA);

   // Port 1 is written last so it wins on an address collision.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         if (v0) regs_q[wa0] <= wd0;
         if (v1) regs_q[wa1] <= wd1;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      assign a = raddr[slice_lo(k, ADDR_W) +: ADDR_W];
      assign d = (a == ZA)             ? '0  :
                 (v1 && wa1 == a)      ? wd1 :
                 (v0 && wa0 == a)      ? wd0 :
                                         regs_q[a];
      assign rdata[slice_lo(k, DATA_W) +: DATA_W] = d;
   end

   grf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NREAD  (NREAD)
   ) u_sb (
      .clk      (clk),
      .clr      (clr),
      .raddr    (raddr),
      .we0      (we0),
      .wa0      (wa0),
      .we1      (we1),
      .wa1      (wa1),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rbusy    (rbusy),
      .pend_cnt (pend_cnt)
   );
endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: directed scenarios plus random vs model.
module tb_grf_mp;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic           clk = 1'b0;
   logic           clr;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]  rbusy;
   logic           we0, we1, rsv_en;
   logic [AW-1:0]  wa0, wa1, rsv_addr;
   logic [DW-1:0]  wd0, wd1;
   logic [AW:0]    pend_cnt;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mregs [DEPTH];
   bit            mpend [DEPTH];

   always #5 clk = ~clk;

   grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
      .clk      (clk),
      .clr      (clr),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .we0      (we0),
      .wa0      (wa0),
      .wd0      (wd0),
      .we1      (we1),
      .wa1      (wa1),
      .wd1      (wd1),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .pend_cnt (pend_cnt)
   );

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
      return mregs[a];
   endfunction

   function automatic bit exp_busy(input logic [AW-1:0] a);
      return (a != 0) && mpend[a] && !(we0 && wa0 == a)
             && !(we1 && wa1 == a);
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int r = 0; r < DEPTH; r++) n += int'(mpend[r]);
      return n;
   endfunction

   task automatic model_step();
      if (clr) begin
         for (int r = 0; r < DEPTH; r++) begin
            mregs[r] = '0;
            mpend[r] = 1'b0;
         end
      end else begin
         for (int r = 1; r < DEPTH; r++) begin
            if (rsv_en && rsv_addr == AW'(r)) mpend[r] = 1'b1;
            else if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r)))
               mpend[r] = 1'b0;
         end
         if (we0 && wa0 != 0) mregs[wa0] = wd0;
         if (we1 && wa1 != 0) mregs[wa1] = wd1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      clr = 0; we0 = 0; we1 = 0; rsv_en = 0;
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsv_addr = '0;
   endtask

   task automatic test_reset();
      idle();
      raddr = '0;
      clr = 1;
      tick();
      clr = 0;
      for (int r = 0; r < DEPTH; r++) begin
         raddr = {AW'(DEPTH - 1 - r), AW'(r)};
         #1;
         checks++;
         if (rdata !== '0 || rbusy !== '0) begin
            errors++;
            $display("FAIL reset_read r=%0d got data=%h busy=%b want 0/0",
                     r, rdata, rbusy);
         end
      end
      checks++;
      if (pend_cnt !== 0) begin
         errors++;
         $display("FAIL reset_cnt got %0d want 0", pend_cnt);
      end
   endtask

   task automatic test_bypass();
      idle();
      we0 = 1; wa0 = 5; wd0 = 32'h1234;
      raddr = {AW'(0), AW'(5)};
      #1;
      checks++;
      if (rdata[DW-1:0] !== 32'h1234) begin
         errors++;
         $display("FAIL bypass_w0 got %h want 00001234", rdata[DW-1:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rdata[DW-1:0] !== 32'h1234) begin
         errors++;
         $display("FAIL stored_w0 got %h want 00001234", rdata[DW-1:0]);
      end
   endtask

   task automatic test_dual_write();
      idle();
      we0 = 1; wa0 = 7; wd0 = 32'hAAAA;
      we1 = 1; wa1 = 7; wd1 = 32'h5555;
      raddr = {AW'(5), AW'(7)};
      #1;
      checks++;
      if (rdata[DW-1:0] !== 32'h5555) begin
         errors++;
         $display("FAIL dual_bypass got %h want 00005555", rdata[DW-1:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rdata !== {32'h1234, 32'h5555}) begin
         errors++;
         $display("FAIL dual_stored got %h want 0000123400005555", rdata);
      end
      we0 = 1; wa0 = 0; wd0 = 32'hFFFF;
      we1 = 1; wa1 = 0; wd1 = 32'hEEEE;
      raddr = '0;
      #1;
      checks++;
      if (rdata !== '0) begin
         errors++;
         $display("FAIL r0_bypass got %h want 0", rdata);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rdata !== '0) begin
         errors++;
         $display("FAIL r0_stored got %h want 0", rdata);
      end
   endtask

   task automatic test_reserve();
      idle();
      rsv_en = 1; rsv_addr = 3;
      raddr = {AW'(0), AW'(3)};
      #1;
      checks++;
      if (rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL rsv_early got %b want 0", rbusy[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rbusy[0] !== 1'b1 || pend_cnt !== 1) begin
         errors++;
         $display("FAIL rsv_set busy=%b cnt=%0d want 1/1", rbusy[0], pend_cnt);
      end
      we1 = 1; wa1 = 3; wd1 = 32'hBEEF;
      #1;
      checks++;
      if (rbusy[0] !== 1'b0 || rdata[DW-1:0] !== 32'hBEEF) begin
         errors++;
         $display("FAIL rsv_wr busy=%b data=%h want 0/0000beef",
                  rbusy[0], rdata[DW-1:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rbusy[0] !== 1'b0 || pend_cnt !== 0) begin
         errors++;
         $display("FAIL rsv_clr busy=%b cnt=%0d want 0/0", rbusy[0], pend_cnt);
      end
   endtask

   task automatic test_rsv_write_same();
      idle();
      rsv_en = 1; rsv_addr = 4;
      tick();
      idle();
      rsv_en = 1; rsv_addr = 4;
      we0 = 1; wa0 = 4; wd0 = 32'h44;
      raddr = {AW'(0), AW'(4)};
      #1;
      checks++;
      if (rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL same_mask got %b want 0", rbusy[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rbusy[0] !== 1'b1 || pend_cnt !== 1 || rdata[DW-1:0] !== 32'h44) begin
         errors++;
         $display("FAIL same_hold busy=%b cnt=%0d data=%h want 1/1/00000044",
                  rbusy[0], pend_cnt, rdata[DW-1:0]);
      end
      rsv_en = 1; rsv_addr = 8;
      tick();
      rsv_addr = 9;
      tick();
      idle();
      #1;
      checks++;
      if (pend_cnt !== 3) begin
         errors++;
         $display("FAIL three_pend got %0d want 3", pend_cnt);
      end
      we0 = 1; wa0 = 8; wd0 = 32'h8;
      we1 = 1; wa1 = 9; wd1 = 32'h9;
      tick();
      idle();
      #1;
      checks++;
      if (pend_cnt !== 1) begin
         errors++;
         $display("FAIL double_clr got %0d want 1", pend_cnt);
      end
      we0 = 1; wa0 = 4; wd0 = 32'h4;
      tick();
      idle();
      #1;
      checks++;
      if (pend_cnt !== 0) begin
         errors++;
         $display("FAIL drain got %0d want 0", pend_cnt);
      end
   endtask

   task automatic test_clr_mid();
      idle();
      for (int i = 0; i < 10; i++) begin
         rsv_en = 1; rsv_addr = AW'(10 + i);
         if (i == 6) begin
            #1;
            checks++;
            if (pend_cnt !== 6) begin
               errors++;
               $display("FAIL pre_clr_cnt got %0d want 6", pend_cnt);
            end
            clr = 1;
            we1 = 1; wa1 = 12; wd1 = 32'hDEAD;
            tick();
            clr = 0; we1 = 0; rsv_en = 0;
            #1;
            checks++;
            if (pend_cnt !== 0) begin
               errors++;
               $display("FAIL clr_cnt got %0d want 0", pend_cnt);
            end
            for (int r = 10; r < 20; r++) begin
               raddr = {AW'(5), AW'(r)};
               #1;
               checks++;
               if (rbusy !== 2'b00) begin
                  errors++;
                  $display("FAIL clr_busy r=%0d got %b want 00", r, rbusy);
               end
            end
            raddr = {AW'(5), AW'(12)};
            #1;
            checks++;
            if (rdata !== '0) begin
               errors++;
               $display("FAIL clr_data got %h want 0", rdata);
            end
         end else begin
            tick();
         end
      end
      idle();
      #1;
      checks++;
      if (pend_cnt !== 3) begin
         errors++;
         $display("FAIL post_clr_cnt got %0d want 3", pend_cnt);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         clr      = ($urandom_range(0, 49) == 0);
         we0      = $urandom_range(0, 1);
         we1      = $urandom_range(0, 1);
         rsv_en   = ($urandom_range(0, 9) < 4);
         wa0      = AW'($urandom_range(0, 7));
         wa1      = AW'($urandom_range(0, 7));
         rsv_addr = AW'($urandom_range(0, 7));
         wd0      = $urandom;
         wd1      = $urandom;
         raddr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         #1;
         for (int k = 0; k < NR; k++) begin
            checks++;
            if (rdata[k*DW +: DW] !== exp_rd(raddr[k*AW +: AW]) ||
                rbusy[k] !== exp_busy(raddr[k*AW +: AW])) begin
               errors++;
               $display("FAIL rand_port n=%0d k=%0d data=%h busy=%b want %h/%b",
                        n, k, rdata[k*DW +: DW], rbusy[k],
                        exp_rd(raddr[k*AW +: AW]),
                        exp_busy(raddr[k*AW +: AW]));
            end
         end
         checks++;
         if (int'(pend_cnt) != exp_cnt()) begin
            errors++;
            $display("FAIL rand_cnt n=%0d got %0d want %0d",
                     n, pend_cnt, exp_cnt());
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_dual_write();
      test_reserve();
      test_rsv_write_same();
      test_clr_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
